ofdm_symbol_reader: RTL and testbench

- Drains the CP-free symbol buffer produced by the time synchronizer and streams it to the FFT as one AXI-Stream-style frame per OFDM symbol.
- Handshakes with the synchronizer through its buffer-full flag, read pointer, read data and tx_done, and pulses tx_done to re-arm it.
- Sits directly downstream of the time-sync stage and upstream of the receive FFT and channel estimator.

---
 rtl/ofdm_symbol_reader_if.sv | 22 ++
 rtl/ofdm_symbol_reader.sv | 172 +++++++++++++++++
 tb/tb_ofdm_symbol_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_symbol_reader_if.sv
// Output sample stream of the OFDM symbol reader: AXI-Stream-style data,
// handshake, frame/user markers and the symbol index travelling with each sample.
interface ofdm_symbol_reader_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic              m_tuser;
   logic [3:0]        sym_idx;

   modport master (
      output m_tdata, m_tvalid, m_tlast, m_tuser, sym_idx,
      input  m_tready
   );

   modport slave (
      input  m_tdata, m_tvalid, m_tlast, m_tuser, sym_idx,
      output m_tready
   );
endinterface

// File: rtl/ofdm_symbol_reader.sv
// OFDM symbol reader: drains the synchronizer's CP-free burst buffer through a
// small first-word-fall-through FIFO and streams it as one frame per symbol.
// The sample tags (tlast/tuser/sym_idx) are derived on the output side from the
// accepted-sample position, so the FIFO only has to carry data.
module ofdm_symbol_reader #(
   parameter int DATA_W      = 8,
   parameter int FFT_POINT   = 64,
   parameter int SYM_NUM     = 12,
   parameter int EST_SYM_NUM = 4,
   parameter int PTR_W       = 10,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_buff_full,
   input  logic [DATA_W-1:0]    i_rd_data,
   output logic [PTR_W-1:0]     o_rd_ptr,
   output logic                 o_rd_en,
   output logic                 o_tx_done,
   output logic                 o_abort,
   ofdm_symbol_reader_if.master m_axis
);

   localparam int FA_W  = $clog2(FIFO_DEPTH);
   localparam int FC_W  = FA_W + 1;
   localparam int OFF_W = $clog2(FFT_POINT);

   localparam logic [PTR_W:0]    TOTAL    = (PTR_W+1)'(FFT_POINT * SYM_NUM);
   localparam logic [PTR_W:0]    LAST_IDX = (PTR_W+1)'(FFT_POINT * SYM_NUM - 1);
   localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(FFT_POINT - 1);
   localparam logic [3:0]        EST_NUM  = 4'(EST_SYM_NUM);
   localparam logic [FC_W-1:0]   DEPTH_C  = FC_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_FETCH    = 2'd1;
   localparam logic [1:0] S_DONE     = 2'd2;
   localparam logic [1:0] S_WAIT_CLR = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [PTR_W:0]    r_iss;      // reads issued in this burst
   logic [PTR_W:0]    r_acc;      // samples accepted downstream in this burst
   logic [OFF_W-1:0]  r_off;      // in-symbol offset of the head sample
   logic [3:0]        r_sym;      // symbol index of the head sample
   logic              r_pend;     // a read was issued last cycle; data arrives now
   logic              r_abort;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [FA_W-1:0]   r_wptr;
   logic [FA_W-1:0]   r_rptr;
   logic [FC_W-1:0]   r_cnt;

   logic              w_valid;
   logic              w_hs;
   logic              w_last_hs;
   logic              w_abort;
   logic [FC_W-1:0]   w_occ;
   logic              w_rd;
   logic              w_push;
   logic              w_clear;

   assign w_valid   = (r_cnt != '0);
   assign w_hs      = w_valid && m_axis.m_tready;
   assign w_last_hs = w_hs && (r_acc == LAST_IDX);
   // The final handshake wins over a simultaneous buff_full drop.
   assign w_abort   = (r_state == S_FETCH) && !i_buff_full && !w_last_hs;
   // Occupancy counts the read in flight so the FIFO can never overflow.
   assign w_occ     = r_cnt + FC_W'(r_pend);
   assign w_rd      = (r_state == S_FETCH) && i_buff_full &&
                      (w_occ < DEPTH_C) && (r_iss < TOTAL);
   assign w_push    = r_pend && !w_abort;
   // Everything burst-related restarts whenever the block heads for IDLE.
   assign w_clear   = (w_state_next == S_IDLE);

   // Next-state selection for the burst controller
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (i_buff_full) w_state_next = S_FETCH;
         S_FETCH: begin
            if (w_last_hs)         w_state_next = S_DONE;
            else if (!i_buff_full) w_state_next = S_IDLE;
         end
         S_DONE:     w_state_next = S_WAIT_CLR;
         S_WAIT_CLR: if (!i_buff_full) w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   // State register and the one-cycle abort pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_abort <= w_abort;
      end
   end

   // Read-issue side: address counter and the one-deep in-flight marker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iss  <= '0;
         r_pend <= 1'b0;
      end else if (w_clear) begin
         r_iss  <= '0;
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_rd;
         if (w_rd) r_iss <= r_iss + (PTR_W+1)'(1);
      end
   end

   // Output-side position tracking: accepted count, symbol offset and index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_off <= '0;
         r_sym <= '0;
      end else if (w_clear) begin
         r_acc <= '0;
         r_off <= '0;
         r_sym <= '0;
      end else if (w_hs) begin
         if (r_acc != TOTAL) r_acc <= r_acc + (PTR_W+1)'(1);
         if (r_off == OFF_LAST) begin
            r_off <= '0;
            r_sym <= r_sym + 4'd1;
         end else begin
            r_off <= r_off + OFF_W'(1);
         end
      end
   end

   // FIFO pointers and occupancy; leaving FETCH for IDLE flushes them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (w_clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FA_W'(1);
         if (w_hs)   r_rptr <= r_rptr + FA_W'(1);
         case ({w_push, w_hs})
            2'b10:   r_cnt <= r_cnt + FC_W'(1);
            2'b01:   r_cnt <= r_cnt - FC_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // FIFO storage: capture the buffer word returned for last cycle's read
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_rd_data;
   end

   // Outputs are gated by valid so an empty FIFO (or reset) shows all zeros.
   assign o_rd_ptr        = r_iss[PTR_W-1:0];
   assign o_rd_en         = w_rd;
   assign o_tx_done       = (r_state == S_DONE);
   assign o_abort         = r_abort;
   assign m_axis.m_tvalid = w_valid;
   assign m_axis.m_tdata  = w_valid ? r_mem[r_rptr] : '0;
   assign m_axis.m_tlast  = w_valid && (r_off == OFF_LAST);
   assign m_axis.m_tuser  = w_valid && (r_sym < EST_NUM);
   assign m_axis.sym_idx  = w_valid ? r_sym : 4'd0;

endmodule

// File: tb/tb_ofdm_symbol_reader.sv
// Bench for ofdm_symbol_reader: buffer model, scoreboard of expected samples,
// and directed scenarios (plain burst, backpressure, abort, WAIT_CLR hold,
// asynchronous reset mid-burst, completion coinciding with buff_full drop).
module tb_ofdm_symbol_reader;

   localparam int DATA_W      = 8;
   localparam int FFT_POINT   = 64;
   localparam int SYM_NUM     = 12;
   localparam int EST_SYM_NUM = 4;
   localparam int PTR_W       = 10;
   localparam int FIFO_DEPTH  = 4;
   localparam int TOTAL       = FFT_POINT * SYM_NUM;

   logic              clk = 1'b0;
   logic              rst;
   logic              buff_full;
   logic [DATA_W-1:0] rd_data = '0;
   logic [PTR_W-1:0]  rd_ptr;
   logic              rd_en;
   logic              tx_done;
   logic              abort;
   logic              bp_en = 1'b0;

   ofdm_symbol_reader_if #(.DATA_W(DATA_W)) axis ();

   ofdm_symbol_reader #(
      .DATA_W(DATA_W), .FFT_POINT(FFT_POINT), .SYM_NUM(SYM_NUM),
      .EST_SYM_NUM(EST_SYM_NUM), .PTR_W(PTR_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .i_buff_full(buff_full), .i_rd_data(rd_data),
      .o_rd_ptr(rd_ptr), .o_rd_en(rd_en), .o_tx_done(tx_done), .o_abort(abort),
      .m_axis(axis)
   );

   always #5 clk = ~clk;

   // Synchronizer buffer model: one-cycle read latency
   logic [DATA_W-1:0] mem_buf [0:(1<<PTR_W)-1];
   always @(posedge clk) if (rd_en) rd_data <= mem_buf[rd_ptr];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard entry: {sym_idx, tuser, tlast, tdata}
   logic [13:0] exp_q[$];
   int cyc = 0, hs_cnt = 0, base = 0, first_hs = -1, last_hs = -1;
   int done_cnt = 0, abort_cnt = 0, outst = 0;
   logic        held_v = 1'b0;
   logic [13:0] held;
   logic [13:0] obs;
   bit          hs;

   function automatic logic [31:0] all_outs();
      return 32'({axis.m_tvalid, axis.m_tdata, axis.m_tlast, axis.m_tuser,
                  axis.sym_idx, rd_en, rd_ptr, tx_done, abort});
   endfunction

   // Fill the buffer with a burst pattern and queue the samples it must produce
   task automatic load(input int p);
      logic [7:0] d;
      for (int i = 0; i < TOTAL; i++) begin
         d = 8'((i + p * 37) % 256);
         mem_buf[i] = d;
         exp_q.push_back({4'(i / FFT_POINT), (i / FFT_POINT) < EST_SYM_NUM,
                          (i % FFT_POINT) == FFT_POINT - 1, d});
      end
   endtask

   // Monitor at the falling edge: scoreboard, stall stability, read limit
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         outst  = 0;
         held_v = 1'b0;
      end else begin
         obs = {axis.sym_idx, axis.m_tuser, axis.m_tlast, axis.m_tdata};
         if (abort) begin
            outst  = 0;
            held_v = 1'b0;
            exp_q.delete();
            abort_cnt++;
         end
         if (held_v && axis.m_tvalid) chk("hold", 32'(obs), 32'(held));
         if (rd_en) chk("rd_limit", 32'(outst < FIFO_DEPTH), 32'd1);
         hs = axis.m_tvalid && axis.m_tready;
         if (hs) begin
            if (exp_q.size() == 0) chk("extra_hs", 32'(obs), 32'h3fff);
            else chk("sample", 32'(obs), 32'(exp_q.pop_front()));
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            held_v  = 1'b0;
         end else if (axis.m_tvalid) begin
            held_v = 1'b1;
            held   = obs;
         end else begin
            held_v = 1'b0;
         end
         outst = outst + int'(rd_en) - int'(hs);
         if (tx_done) done_cnt++;
      end
   end

   // Downstream ready: always 1, or a pseudo-random stall pattern
   initial begin
      axis.m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         axis.m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Raise buff_full on an idle block and check the start-up latency
   task automatic launch(input int p);
      load(p);
      first_hs  = -1;
      base      = hs_cnt;
      buff_full = 1'b1;
      @(posedge clk); #1;
      chk("lat_rd", 32'({rd_en, rd_ptr, axis.m_tvalid}), 32'({1'b1, 10'd0, 1'b0}));
      @(posedge clk); #1;
      chk("lat_v1", 32'(axis.m_tvalid), 32'd0);
      @(posedge clk); #1;
      chk("lat_v2", 32'(axis.m_tvalid), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int max);
      bit ok = 0;
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (tx_done) begin ok = 1; break; end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_hs(input string tag, input int n);
      bit ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (hs_cnt - base >= n) begin ok = 1; break; end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic go_idle(input int n);
      buff_full = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0, a0, n;
      bit ok;
      rst       = 1'b1;
      buff_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", all_outs(), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_outs", all_outs(), 32'd0);

      // Plain burst, ready held high
      d0 = done_cnt;
      launch(0);
      wait_done("b1_done", 2000);
      chk("b1_hs", 32'(hs_cnt - base), 32'(TOTAL));
      chk("b1_gapless", 32'(last_hs - first_hs), 32'(TOTAL - 1));
      chk("b1_q_empty", 32'(exp_q.size()), 32'd0);
      $display("burst 1: %0d samples in %0d cycles", hs_cnt - base, last_hs - first_hs + 1);

      // WAIT_CLR hold: buff_full stays high, nothing may be read or streamed
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (rd_en || axis.m_tvalid || tx_done) n++;
      end
      chk("wc_quiet", 32'(n), 32'd0);
      chk("b1_done_cnt", 32'(done_cnt - d0), 32'd1);
      $display("wait_clr: held 20 cycles, activity=%0d", n);
      go_idle(3);

      // Second burst after re-arming
      launch(1);
      wait_done("b2_done", 2000);
      chk("b2_hs", 32'(hs_cnt - base), 32'(TOTAL));
      $display("burst 2: %0d samples", hs_cnt - base);
      go_idle(3);

      // Backpressure
      bp_en = 1'b1;
      launch(2);
      wait_done("bp_done", 8000);
      chk("bp_hs", 32'(hs_cnt - base), 32'(TOTAL));
      chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("backpressure burst: %0d samples", hs_cnt - base);
      bp_en = 1'b0;
      go_idle(3);

      // Abort after 100 handshakes
      d0 = done_cnt;
      a0 = abort_cnt;
      launch(3);
      wait_hs("ab_reach", 100);
      buff_full = 1'b0;
      @(posedge clk); #1;
      chk("ab_pulse", 32'({abort, axis.m_tvalid, tx_done}), 32'b100);
      @(posedge clk); #1;
      chk("ab_end", 32'({abort, axis.m_tvalid}), 32'b00);
      repeat (3) @(posedge clk);
      #1;
      chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
      chk("ab_cnt", 32'(abort_cnt - a0), 32'd1);
      $display("abort: after %0d samples", hs_cnt - base);
      launch(3);
      wait_done("ab_restart_done", 2000);
      chk("ab_restart_hs", 32'(hs_cnt - base), 32'(TOTAL));
      go_idle(3);

      // Asynchronous reset around sample 300
      launch(4);
      wait_hs("rst_reach", 300);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_outs", all_outs(), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      load(4);
      base = hs_cnt;
      @(posedge clk); #1;
      chk("arst_restart", 32'({rd_en, rd_ptr}), 32'({1'b1, 10'd0}));
      wait_done("arst_done", 2000);
      chk("arst_hs", 32'(hs_cnt - base), 32'(TOTAL));
      $display("async reset: restarted burst %0d samples", hs_cnt - base);
      go_idle(3);

      // buff_full drops on the very edge of the final handshake
      a0 = abort_cnt;
      launch(5);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (axis.m_tvalid && axis.m_tlast && axis.sym_idx == 4'(SYM_NUM - 1)) begin
            ok = 1;
            break;
         end
      end
      chk("edge_reach", 32'(ok), 32'd1);
      buff_full = 1'b0;
      @(posedge clk); #1;
      chk("edge_done", 32'({tx_done, abort}), 32'b10);
      @(posedge clk); #1;
      chk("edge_after", 32'({tx_done, abort}), 32'b00);
      chk("edge_abort_cnt", 32'(abort_cnt - a0), 32'd0);
      chk("edge_hs", 32'(hs_cnt - base), 32'(TOTAL));
      $display("edge coincidence: %0d samples", hs_cnt - base);
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
